// File: rtl/comparator_edge_capture.sv
// Multi-channel comparator trip capture: negedge-sampled, glitch-filtered inputs; first qualified trip latches a shared-counter timestamp.
// Latency: cmp_in seen at next negedge, evaluated at following posedge; tripped/trip_pulse/ts update one posedge after qualification.
// Backpressure: none; outputs hold in DONE until re-armed by start or cleared by rst.
//
// Ports: clk, rst (sync, active-high), start (arm/re-arm), pol[N_CH] (1 = trip on high),
//        cmp_in[N_CH] -> trip_pulse[N_CH], tripped[N_CH], ts_flat[N_CH*TS_W] (ch i at [i*TS_W +: TS_W]),
//        busy (ARMED), done (DONE), timeout (DONE with untripped channels at counter saturation).
module comparator_edge_capture #(
    parameter int N_CH = 4,
    parameter int TS_W = 16,
    parameter int FILT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_CH-1:0]        pol,
    input  logic [N_CH-1:0]        cmp_in,
    output logic [N_CH-1:0]        trip_pulse,
    output logic [N_CH-1:0]        tripped,
    output logic [N_CH*TS_W-1:0]   ts_flat,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout
);

    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [TS_W-1:0] CNT_MAX   = '1;
    localparam logic [FW-1:0]   FILT_LAST = FW'(FILT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TS_W-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0]   tripped_q, tripped_d;
    logic [N_CH-1:0]   trip_pulse_q, trip_pulse_d;
    logic              timeout_q, timeout_d;
    logic [TS_W-1:0]   ts_q   [N_CH];
    logic [TS_W-1:0]   ts_d   [N_CH];
    logic [FW-1:0]     filt_q [N_CH];
    logic [FW-1:0]     filt_d [N_CH];
    logic [N_CH-1:0]   neg_q, neg_d;
    logic [N_CH-1:0]   active;
    logic [N_CH-1:0]   new_trip;

    // Half-cycle input sampler: gives the comparator half a clock to settle
    // before the posedge logic consumes it.
    always_comb neg_d = cmp_in;

    always_ff @(negedge clk) begin
        neg_q <= neg_d;
    end

    assign active = ~(neg_q ^ pol);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tripped_d    = tripped_q;
        trip_pulse_d = '0;
        timeout_d    = timeout_q;
        new_trip     = '0;
        for (int i = 0; i < N_CH; i++) begin
            ts_d[i]   = ts_q[i];
            filt_d[i] = '0;
        end

        if (start) begin
            // Arm/re-arm from any state; trips evaluated this cycle are dropped.
            state_d   = ST_ARMED;
            cnt_d     = '0;
            tripped_d = '0;
            timeout_d = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ts_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_ARMED: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (!tripped_q[i] && active[i]) begin
                            if (filt_q[i] == FILT_LAST) begin
                                new_trip[i] = 1'b1;
                                ts_d[i]     = cnt_q;
                            end else begin
                                filt_d[i] = filt_q[i] + FW'(1);
                            end
                        end
                    end
                    tripped_d    = tripped_q | new_trip;
                    trip_pulse_d = new_trip;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + TS_W'(1);
                    end
                    // A trip on the saturation cycle counts before timeout is judged.
                    if (&tripped_d) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = ST_DONE;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tripped_q    <= '0;
            trip_pulse_q <= '0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                ts_q[i]   <= '0;
                filt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tripped_q    <= tripped_d;
            trip_pulse_q <= trip_pulse_d;
            timeout_q    <= timeout_d;
            for (int i = 0; i < N_CH; i++) begin
                ts_q[i]   <= ts_d[i];
                filt_q[i] <= filt_d[i];
            end
        end
    end

    always_comb begin
        ts_flat = '0;
        for (int i = 0; i < N_CH; i++) begin
            ts_flat[i*TS_W +: TS_W] = ts_q[i];
        end
    end

    assign trip_pulse = trip_pulse_q;
    assign tripped    = tripped_q;
    assign busy       = (state_q == ST_ARMED);
    assign done       = (state_q == ST_DONE);
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_comparator_edge_capture.sv
// Bench for comparator_edge_capture: a 16-bit timestamp instance and a 4-bit one share stimulus.
// Inputs are driven 1 time unit after posedge and sampled by the DUT at the following negedge.
// Outputs are checked 1 time unit after posedge.
module tb_comparator_edge_capture;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  pol;
    logic [3:0]  cmp_in;

    logic [3:0]  pulse16, trip16, pulse4, trip4;
    logic [63:0] ts16;
    logic [15:0] ts4;
    logic        busy16, done16, tmo16, busy4, done4, tmo4;

    int checks = 0;
    int errors = 0;

    comparator_edge_capture #(.N_CH(4), .TS_W(16), .FILT(2)) dut16 (
        .clk(clk), .rst(rst), .start(start), .pol(pol), .cmp_in(cmp_in),
        .trip_pulse(pulse16), .tripped(trip16), .ts_flat(ts16),
        .busy(busy16), .done(done16), .timeout(tmo16)
    );

    comparator_edge_capture #(.N_CH(4), .TS_W(4), .FILT(2)) dut4 (
        .clk(clk), .rst(rst), .start(start), .pol(pol), .cmp_in(cmp_in),
        .trip_pulse(pulse4), .tripped(trip4), .ts_flat(ts4),
        .busy(busy4), .done(done4), .timeout(tmo4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] cmp;
        logic [3:0] pulse;
        logic [3:0] trip;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        // Staggered rises: ch i goes active at armed cycle 3+2i, trips one cycle later.
        tbl[0]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[4]  = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0};
        tbl[5]  = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0010, 4'b0011, 1'b1, 1'b0};
        tbl[7]  = '{4'b0111, 4'b0000, 4'b0011, 1'b1, 1'b0};
        tbl[8]  = '{4'b0111, 4'b0100, 4'b0111, 1'b1, 1'b0};
        tbl[9]  = '{4'b1111, 4'b0000, 4'b0111, 1'b1, 1'b0};
        tbl[10] = '{4'b1111, 4'b1000, 4'b1111, 1'b0, 1'b1};
        tbl[11] = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b1};

        rst    = 1'b1;
        start  = 1'b0;
        pol    = 4'hF;
        cmp_in = 4'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_pulse",   pulse16, 0);
        chk("rst_tripped", trip16,  0);
        chk("rst_ts",      ts16,    0);
        chk("rst_busy",    busy16,  0);
        chk("rst_done",    done16,  0);
        chk("rst_timeout", tmo16,   0);
        chk("rst_ts4",     ts4,     0);

        // Idle: toggling inputs must not trip
        for (int k = 0; k < 6; k++) begin
            cmp_in = (k % 2 == 1) ? 4'hF : 4'h0;
            tick();
            chk("idle_pulse",   pulse16, 0);
            chk("idle_tripped", trip16,  0);
            chk("idle_busy",    busy16,  0);
            chk("idle_done",    done16,  0);
        end
        cmp_in = 4'h0;

        // Staggered trips from the table
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("arm_busy", busy16, 1);
        chk("arm_done", done16, 0);
        for (int r = 0; r < 12; r++) begin
            cmp_in = tbl[r].cmp;
            tick();
            chk($sformatf("tbl%0d_pulse", r),   pulse16, tbl[r].pulse);
            chk($sformatf("tbl%0d_tripped", r), trip16,  tbl[r].trip);
            chk($sformatf("tbl%0d_busy", r),    busy16,  tbl[r].busy);
            chk($sformatf("tbl%0d_done", r),    done16,  tbl[r].done);
        end
        chk("stag_timeout", tmo16, 0);
        chk("stag_ts",      ts16,  64'h000A_0008_0006_0004);
        chk("stag_ts4",     ts4,   16'hA864);
        chk("stag_done4",   done4, 1);
        chk("stag_tmo4",    tmo4,  0);

        // Glitch on ch1, inverted polarity on ch2; 4-bit instance times out
        pol    = 4'b1011;
        cmp_in = 4'h0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 22; c++) begin
            cmp_in = {2'b00, ((c == 5) || (c >= 20)), 1'b0};
            tick();
            if (c == 1)  chk("pol_pulse",       pulse16, 4'b0100);
            if (c == 6)  chk("glitch_tripped",  trip16,  4'b0100);
            if (c == 20) chk("glitch_pre",      pulse16, 4'b0000);
            if (c == 21) chk("glitch_pulse",    pulse16, 4'b0010);
            if (c == 14) chk("tmo4_busy_pre",   busy4,   1);
            if (c == 15) begin
                chk("tmo4_busy",    busy4, 0);
                chk("tmo4_done",    done4, 1);
                chk("tmo4_timeout", tmo4,  1);
                chk("tmo4_tripped", trip4, 4'b0100);
            end
        end
        chk("glitch_ts",      ts16,   64'h0000_0001_0015_0000);
        chk("glitch_tripped_end", trip16, 4'b0110);
        chk("glitch_busy",    busy16, 1);
        chk("glitch_done",    done16, 0);
        chk("tmo4_hold",      trip4,  4'b0100);
        chk("tmo4_hold_tmo",  tmo4,   1);

        // ch3 trips exactly on the saturation cycle of the 4-bit instance
        pol   = 4'hF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 16; c++) begin
            cmp_in = {(c >= 14), 3'b111};
            tick();
            if (c == 1)  chk("sat_pulse_low", pulse4, 4'b0111);
            if (c == 14) chk("sat_busy_pre",  busy4,  1);
            if (c == 15) begin
                chk("sat_pulse3",  pulse4, 4'b1000);
                chk("sat_done",    done4,  1);
                chk("sat_timeout", tmo4,   0);
                chk("sat_tripped", trip4,  4'hF);
            end
            if (c == 16) chk("sat_pulse_end", pulse4, 4'b0000);
        end
        chk("sat_ts4", ts4, 16'hF111);

        // Re-arm mid-ARMED after two trips; ch2 would qualify on the re-arm cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            cmp_in = (c >= 3) ? 4'b0111 : 4'b0011;
            tick();
            if (c == 1) chk("rearm_two", trip16, 4'b0011);
        end
        cmp_in = 4'b0111;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("rearm_tripped", trip16,  0);
        chk("rearm_ts",      ts16,    0);
        chk("rearm_pulse",   pulse16, 0);
        chk("rearm_busy",    busy16,  1);
        tick();
        chk("rearm_c0", trip16, 0);
        tick();
        chk("rearm_c1_pulse", pulse16, 4'b0111);
        chk("rearm_c1_ts",    ts16,    64'h0000_0001_0001_0001);

        // Reset mid-ARMED
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_pulse",   pulse16, 0);
        chk("mrst_tripped", trip16,  0);
        chk("mrst_ts",      ts16,    0);
        chk("mrst_busy",    busy16,  0);
        chk("mrst_done",    done16,  0);
        chk("mrst_timeout", tmo16,   0);
        chk("mrst_busy4",   busy4,   0);
        tick();
        chk("mrst_idle_pulse", pulse16, 0);
        chk("mrst_idle_busy",  busy16,  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
